// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one cache read at a time and
// hands returned instructions to decode through a 2-entry {pc,instr} buffer.
module fetch_controller #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              cache_req_valid,
  output logic [ADDR_W-1:0] cache_req_addr,
  input  logic              cache_req_ready,
  input  logic              cache_resp_valid,
  input  logic [DATA_W-1:0] cache_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              discard, discard_next;
  logic [ADDR_W-1:0] buf_pc [2];
  logic [DATA_W-1:0] buf_instr [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count, count_next;
  logic [1:0]        occ_after_pop;
  logic              push, pop, flush;

  // A pop in a redirect cycle is ignored because the buffer is flushed anyway.
  assign pop           = (count != 2'd0) && dec_ready && !redirect_valid;
  assign occ_after_pop = count - {1'b0, pop};

  assign cache_req_valid = !rst && (state == S_REQ) && (occ_after_pop < 2'd2);
  assign cache_req_addr  = pc;
  assign dec_valid       = !rst && (count != 2'd0);
  assign dec_pc          = buf_pc[rd_ptr];
  assign dec_instr       = buf_instr[rd_ptr];

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    discard_next = discard;
    push         = 1'b0;
    flush        = 1'b0;
    if (redirect_valid) begin
      pc_next = redirect_pc;
      flush   = 1'b1;
      unique case (state)
        S_WAIT: begin
          if (cache_resp_valid) begin
            discard_next = 1'b0;
            state_next   = S_REQ;
          end else begin
            discard_next = 1'b1;
          end
        end
        // A request accepted this cycle is still in flight; its data must be dropped.
        S_REQ: begin
          if (cache_req_valid && cache_req_ready) begin
            discard_next = 1'b1;
            state_next   = S_WAIT;
          end
        end
        default: state_next = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (cache_req_valid && cache_req_ready) begin
            pc_next    = pc + ADDR_W'(1);
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cache_resp_valid) begin
            if (discard) begin
              discard_next = 1'b0;
              state_next   = S_REQ;
            end else begin
              push       = 1'b1;
              state_next = (occ_after_pop == 2'd0) ? S_REQ : S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (occ_after_pop < 2'd2) state_next = S_REQ;
        end
        default: state_next = S_REQ;
      endcase
    end
  end

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
    if (flush) count_next = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      discard <= discard_next;
      count   <= count_next;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  // The PC was already advanced at accept time, so the returning instruction belongs to pc-1.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      buf_pc[wr_ptr]    <= pc - ADDR_W'(1);
      buf_instr[wr_ptr] <= cache_resp_data;
    end
  end

endmodule
